// File: rtl/risc_toy_fetch_buffer_if.sv
// Fetch-buffer bus bundle: instruction-memory request/response, EX redirect, and ID handshake.
// The master side is the fetch buffer; the slave side is the surrounding pipeline and memory.
interface risc_toy_fetch_buffer_if #(
    parameter int unsigned AW    = 30,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
);
    logic                     IREQ;
    logic [AW-1:0]            IADDR;
    logic [DW-1:0]            INSTR;
    logic                     REDIR;
    logic [AW-1:0]            REDIR_ADDR;
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic [DW-1:0]            OUT_INSTR;
    logic [AW-1:0]            OUT_ADDR;
    logic [$clog2(DEPTH):0]   COUNT;

    modport master (
        output IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_ADDR, COUNT,
        input  INSTR, REDIR, REDIR_ADDR, OUT_READY
    );

    modport slave (
        input  IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_ADDR, COUNT,
        output INSTR, REDIR, REDIR_ADDR, OUT_READY
    );
endinterface

// File: rtl/risc_toy_fetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency memory requests and
// queues responses in order for ID; a redirect flushes the queue and kills the in-flight response.
module risc_toy_fetch_buffer #(
    parameter int unsigned   AW         = 30,
    parameter int unsigned   DW         = 32,
    parameter int unsigned   DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input logic                     CLK,
    input logic                     RSTN,
    risc_toy_fetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthOcc = DEPTH[CW:0];

    logic [AW-1:0]    fpc_q, fpc_d;
    logic             started_q;
    logic             inflight_q, inflight_d;
    logic [AW-1:0]    inflight_addr_q, inflight_addr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW+AW-1:0] mem_q [DEPTH];

    logic             pop;
    logic             push;
    logic             ireq;
    logic [CW:0]      occ;

    always_comb begin
        pop  = (count_q != '0) & bus.OUT_READY;
        push = inflight_q & ~bus.REDIR;
        // Credit counts the in-flight response so a push can never land on a full queue.
        occ  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        ireq = started_q & ~bus.REDIR & (occ < DepthOcc);
    end

    always_comb begin
        fpc_d           = fpc_q;
        inflight_d      = ireq;
        inflight_addr_d = inflight_addr_q;
        rptr_d          = rptr_q;
        wptr_d          = wptr_q;
        count_d         = count_q;
        if (bus.REDIR) begin
            fpc_d   = bus.REDIR_ADDR;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (ireq) begin
                fpc_d           = fpc_q + AW'(1);
                inflight_addr_d = fpc_q;
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fpc_q           <= RESET_ADDR;
            started_q       <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            rptr_q          <= '0;
            wptr_q          <= '0;
            count_q         <= '0;
        end else begin
            fpc_q           <= fpc_d;
            started_q       <= 1'b1;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            rptr_q          <= rptr_d;
            wptr_q          <= wptr_d;
            count_q         <= count_d;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= {bus.INSTR, inflight_addr_q};
        end
    end

    assign bus.IREQ      = ireq;
    assign bus.IADDR     = fpc_q;
    assign bus.OUT_VALID = (count_q != '0);
    assign bus.OUT_INSTR = mem_q[rptr_q][DW+AW-1:AW];
    assign bus.OUT_ADDR  = mem_q[rptr_q][AW-1:0];
    assign bus.COUNT     = count_q;
endmodule

// File: tb/tb_risc_toy_fetch_buffer.sv
// Bench for risc_toy_fetch_buffer: constant vector table for credit/wrap cases, directed redirect and
// async-reset sequences, and a randomized run against a queue-based reference model.
module tb_risc_toy_fetch_buffer;
    localparam int unsigned   AW        = 30;
    localparam int unsigned   DW        = 32;
    localparam int unsigned   DEPTH     = 4;
    localparam logic [AW-1:0] WRAP_ADDR = 30'h3FFF_FFFE;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    risc_toy_fetch_buffer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus0 ();
    risc_toy_fetch_buffer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus1 ();

    risc_toy_fetch_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_ADDR('0)) dut0 (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus0)
    );

    risc_toy_fetch_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_ADDR(WRAP_ADDR)) dut1 (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus1)
    );

    assign bus1.OUT_READY  = bus0.OUT_READY;
    assign bus1.REDIR      = bus0.REDIR;
    assign bus1.REDIR_ADDR = bus0.REDIR_ADDR;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 | {2'b00, a};
    endfunction

    // One-cycle-latency instruction memory per DUT.
    always @(posedge CLK) bus0.INSTR <= bus0.IREQ ? mem_word(bus0.IADDR) : 32'hDEAD_BEEF;
    always @(posedge CLK) bus1.INSTR <= bus1.IREQ ? mem_word(bus1.IADDR) : 32'hDEAD_BEEF;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of queued word addresses plus the fetch-side state.
    logic [AW-1:0] m_q[$];
    logic [AW-1:0] m_fpc;
    logic [AW-1:0] m_infl_addr;
    bit            m_infl;
    bit            m_started;

    task automatic model_reset();
        m_q.delete();
        m_fpc       = '0;
        m_infl_addr = '0;
        m_infl      = 1'b0;
        m_started   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN            = 1'b0;
        bus0.OUT_READY  = 1'b0;
        bus0.REDIR      = 1'b0;
        bus0.REDIR_ADDR = '0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
    endtask

    // One cycle on dut0: drive, compare against the model, advance the model, wait for next cycle.
    task automatic step(input bit ready, input bit redir, input logic [AW-1:0] raddr);
        bit e_valid, e_pop, e_ireq;
        bus0.OUT_READY  = ready;
        bus0.REDIR      = redir;
        bus0.REDIR_ADDR = raddr;
        #1;
        e_valid = (m_q.size() != 0);
        e_pop   = e_valid && ready;
        e_ireq  = m_started && !redir &&
                  (int'(m_q.size()) + int'(m_infl) - int'(e_pop) < int'(DEPTH));
        check("ireq", 64'(bus0.IREQ), 64'(e_ireq));
        check("iaddr", 64'(bus0.IADDR), 64'(m_fpc));
        check("out_valid", 64'(bus0.OUT_VALID), 64'(e_valid));
        check("count", 64'(bus0.COUNT), 64'(m_q.size()));
        check("count_bound", 64'(bus0.COUNT <= DEPTH), 64'(1));
        if (e_valid) begin
            check("out_addr", 64'(bus0.OUT_ADDR), 64'(m_q[0]));
            check("out_instr", 64'(bus0.OUT_INSTR), 64'(mem_word(m_q[0])));
        end
        if (redir) begin
            m_q.delete();
            m_infl = 1'b0;
            m_fpc  = raddr;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_addr);
            if (e_ireq) begin
                m_infl_addr = m_fpc;
                m_fpc       = m_fpc + 1'b1;
            end
            m_infl = e_ireq;
        end
        m_started = 1'b1;
        @(negedge CLK);
    endtask

    typedef struct {
        bit            rst_before;
        bit            sel;
        bit            ready;
        bit            exp_ireq;
        logic [AW-1:0] exp_iaddr;
        bit            exp_valid;
        logic [AW-1:0] exp_addr;
        int unsigned   exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit sel, input bit ready, input bit ireq,
                       input logic [AW-1:0] iaddr, input bit valid, input logic [AW-1:0] addr,
                       input int unsigned cnt);
        vec_t v;
        v.rst_before = rst;
        v.sel        = sel;
        v.ready      = ready;
        v.exp_ireq   = ireq;
        v.exp_iaddr  = iaddr;
        v.exp_valid  = valid;
        v.exp_addr   = addr;
        v.exp_count  = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        bit            a_ireq, a_valid;
        logic [AW-1:0] a_iaddr, a_addr;
        logic [DW-1:0] a_instr;
        logic [63:0]   a_count;

        bus0.OUT_READY  = 1'b0;
        bus0.REDIR      = 1'b0;
        bus0.REDIR_ADDR = '0;
        model_reset();

        // Credit stall with ID blocked, then drain (dut0, cycles 0..12 after reset release).
        add(1, 0, 0, 0, 30'd0, 0, 30'd0, 0);
        add(0, 0, 0, 1, 30'd0, 0, 30'd0, 0);
        add(0, 0, 0, 1, 30'd1, 0, 30'd0, 0);
        add(0, 0, 0, 1, 30'd2, 1, 30'd0, 1);
        add(0, 0, 0, 1, 30'd3, 1, 30'd0, 2);
        add(0, 0, 0, 0, 30'd4, 1, 30'd0, 3);
        add(0, 0, 0, 0, 30'd4, 1, 30'd0, 4);
        add(0, 0, 0, 0, 30'd4, 1, 30'd0, 4);
        add(0, 0, 1, 1, 30'd4, 1, 30'd0, 4);
        add(0, 0, 1, 1, 30'd5, 1, 30'd1, 3);
        add(0, 0, 1, 1, 30'd6, 1, 30'd2, 3);
        add(0, 0, 1, 1, 30'd7, 1, 30'd3, 3);
        add(0, 0, 1, 1, 30'd8, 1, 30'd4, 3);
        // Address wrap from RESET_ADDR near the top (dut1).
        add(1, 1, 1, 0, 30'h3FFF_FFFE, 0, 30'd0, 0);
        add(0, 1, 1, 1, 30'h3FFF_FFFE, 0, 30'd0, 0);
        add(0, 1, 1, 1, 30'h3FFF_FFFF, 0, 30'd0, 0);
        add(0, 1, 1, 1, 30'h0000_0000, 1, 30'h3FFF_FFFE, 1);
        add(0, 1, 1, 1, 30'h0000_0001, 1, 30'h3FFF_FFFF, 1);
        add(0, 1, 1, 1, 30'h0000_0002, 1, 30'h0000_0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            bus0.OUT_READY = vecs[i].ready;
            bus0.REDIR     = 1'b0;
            #1;
            if (vecs[i].sel) begin
                a_ireq = bus1.IREQ; a_iaddr = bus1.IADDR; a_valid = bus1.OUT_VALID;
                a_addr = bus1.OUT_ADDR; a_instr = bus1.OUT_INSTR; a_count = 64'(bus1.COUNT);
            end else begin
                a_ireq = bus0.IREQ; a_iaddr = bus0.IADDR; a_valid = bus0.OUT_VALID;
                a_addr = bus0.OUT_ADDR; a_instr = bus0.OUT_INSTR; a_count = 64'(bus0.COUNT);
            end
            check($sformatf("tbl%0d ireq", i), 64'(a_ireq), 64'(vecs[i].exp_ireq));
            check($sformatf("tbl%0d iaddr", i), 64'(a_iaddr), 64'(vecs[i].exp_iaddr));
            check($sformatf("tbl%0d valid", i), 64'(a_valid), 64'(vecs[i].exp_valid));
            check($sformatf("tbl%0d count", i), a_count, 64'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d out_addr", i), 64'(a_addr), 64'(vecs[i].exp_addr));
                check($sformatf("tbl%0d out_instr", i), 64'(a_instr),
                      64'(mem_word(vecs[i].exp_addr)));
            end
            @(negedge CLK);
        end

        // Streaming from reset with ID always ready.
        do_reset();
        repeat (10) step(1'b1, 1'b0, '0);

        // Redirect with two queued entries and one response in flight.
        do_reset();
        repeat (4) step(1'b0, 1'b0, '0);
        #1;
        check("t3 count before redir", 64'(bus0.COUNT), 64'(2));
        step(1'b0, 1'b1, 30'h100);
        bus0.REDIR     = 1'b0;
        bus0.OUT_READY = 1'b1;
        #1;
        check("t3 count after redir", 64'(bus0.COUNT), 64'(0));
        check("t3 ireq after redir", 64'(bus0.IREQ), 64'(1));
        check("t3 iaddr after redir", 64'(bus0.IADDR), 64'(30'h100));
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        #1;
        check("t3 first valid", 64'(bus0.OUT_VALID), 64'(1));
        check("t3 first out_addr", 64'(bus0.OUT_ADDR), 64'(30'h100));
        repeat (6) step(1'b1, 1'b0, '0);

        // Asynchronous reset mid-cycle with three entries queued.
        do_reset();
        repeat (5) step(1'b0, 1'b0, '0);
        #1;
        check("t5 count before reset", 64'(bus0.COUNT), 64'(3));
        #1;
        RSTN = 1'b0;
        #1;
        check("t5 async ireq", 64'(bus0.IREQ), 64'(0));
        check("t5 async valid", 64'(bus0.OUT_VALID), 64'(0));
        check("t5 async count", 64'(bus0.COUNT), 64'(0));
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        repeat (8) step(1'b1, 1'b0, '0);

        // Random back-pressure and redirects.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            step(1'($urandom_range(1)), ($urandom_range(99) < 2), AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
